// File: rtl/s_poly_writer_if.sv
// Sampler-to-writer coefficient beats plus the coefficient RAM write port and status.
interface s_poly_writer_if #(
    parameter int unsigned DLEN = 64,
    parameter int unsigned AW   = 11
);
    logic            start;
    logic            coef_valid;
    logic [1:0]      coef_cnt;
    logic [22:0]     coef0;
    logic [22:0]     coef1;
    logic            coef_ready;
    logic            mem_wen;
    logic [AW-1:0]   mem_waddr;
    logic [DLEN-1:0] mem_din;
    logic            poly_done;
    logic            done;
    logic            overflow_err;

    modport master (
        output start, coef_valid, coef_cnt, coef0, coef1,
        input  coef_ready, mem_wen, mem_waddr, mem_din, poly_done, done, overflow_err
    );

    modport slave (
        input  start, coef_valid, coef_cnt, coef0, coef1,
        output coef_ready, mem_wen, mem_waddr, mem_din, poly_done, done, overflow_err
    );
endinterface

// File: rtl/s_poly_writer.sv
// Packs sampled s1/s2 coefficients two per RAM word, tracking coefficient and
// polynomial indices and flagging per-polynomial and whole-vector completion.
module s_poly_writer #(
    parameter int unsigned DLEN  = 64,
    parameter int unsigned NPOLY = 15,
    parameter int unsigned AW    = 11
) (
    input  logic           clk,
    input  logic           reset,
    s_poly_writer_if.slave bus
);
    localparam int unsigned CW    = 23;
    localparam int unsigned IW    = 9;
    localparam int unsigned PW    = (NPOLY > 1) ? $clog2(NPOLY) : 1;
    localparam int unsigned NCOEF = 256;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   coef_idx_q, coef_idx_d;
    logic [PW-1:0]   poly_idx_q, poly_idx_d;
    logic            pend_q, pend_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            ready_q, ready_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DLEN-1:0] din_q, din_d;
    logic            pdone_q, pdone_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic [1:0]      k, take;
    logic [IW-1:0]   room, new_idx;
    logic            wr;
    logic [CW-1:0]   odd, even;

    // State and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            coef_idx_q <= '0;
            poly_idx_q <= '0;
            pend_q     <= 1'b0;
            hold_q     <= '0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            din_q      <= '0;
            pdone_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            coef_idx_q <= coef_idx_d;
            poly_idx_q <= poly_idx_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            addr_q     <= addr_d;
            ready_q    <= ready_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            din_q      <= din_d;
            pdone_q    <= pdone_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next state, pairing and index bookkeeping
    always_comb begin
        state_d    = state_q;
        coef_idx_d = coef_idx_q;
        poly_idx_d = poly_idx_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        addr_d     = addr_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        din_d      = din_q;
        pdone_d    = 1'b0;
        ovf_d      = ovf_q;
        k          = 2'd0;
        take       = 2'd0;
        room       = IW'(NCOEF) - coef_idx_q;
        new_idx    = coef_idx_q;
        wr         = 1'b0;
        odd        = '0;
        even       = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    coef_idx_d = '0;
                    poly_idx_d = '0;
                    pend_d     = 1'b0;
                    addr_d     = '0;
                    ovf_d      = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.coef_valid) begin
                    if (bus.coef_cnt == 2'd3) begin
                        ovf_d = 1'b1;
                    end else begin
                        k = bus.coef_cnt;
                    end
                    // room is at least 1 here, so truncation only ever trims k=2 to 1
                    if (IW'(k) > room) begin
                        take  = 2'(room);
                        ovf_d = 1'b1;
                    end else begin
                        take = k;
                    end
                    new_idx = coef_idx_q + IW'(take);

                    case ({pend_q, take})
                        3'b0_01: begin
                            hold_d = bus.coef0;
                            pend_d = 1'b1;
                        end
                        3'b0_10: begin
                            wr   = 1'b1;
                            odd  = bus.coef1;
                            even = bus.coef0;
                        end
                        3'b1_01: begin
                            wr     = 1'b1;
                            odd    = bus.coef0;
                            even   = hold_q;
                            pend_d = 1'b0;
                        end
                        3'b1_10: begin
                            wr     = 1'b1;
                            odd    = bus.coef0;
                            even   = hold_q;
                            hold_d = bus.coef1;
                        end
                        default: ;
                    endcase

                    if (new_idx == IW'(NCOEF)) begin
                        coef_idx_d = '0;
                        poly_idx_d = poly_idx_q + PW'(1);
                        pdone_d    = 1'b1;
                        if (poly_idx_q == PW'(NPOLY - 1)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        coef_idx_d = new_idx;
                    end

                    if (wr) begin
                        wen_d   = 1'b1;
                        waddr_d = addr_q;
                        addr_d  = addr_q + AW'(1);
                        din_d   = DLEN'({odd, even});
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    assign bus.coef_ready   = ready_q;
    assign bus.mem_wen      = wen_q;
    assign bus.mem_waddr    = waddr_q;
    assign bus.mem_din      = din_q;
    assign bus.poly_done    = pdone_q;
    assign bus.done         = done_q;
    assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_s_poly_writer.sv
// Bench for s_poly_writer: directed sequences, a vector table and random beats
// checked against a coefficient-stream model.
module tb_s_poly_writer;
    localparam int unsigned DLEN  = 64;
    localparam int unsigned NPOLY = 2;
    localparam int unsigned AW    = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    s_poly_writer_if #(.DLEN(DLEN), .AW(AW)) bus ();

    s_poly_writer #(.DLEN(DLEN), .NPOLY(NPOLY), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: a stream of accepted coefficients, paired in arrival order
    bit          m_run, m_done, m_ovf;
    int          m_n, m_poly, m_addr;
    logic [22:0] held[$];
    logic        e_wen, e_pd, e_ready, e_done, e_ovf;
    logic [AW-1:0]   e_addr;
    logic [DLEN-1:0] e_din;

    typedef struct {
        logic        st, v;
        logic [1:0]  c;
        logic [22:0] a, b;
        logic        wen;
        logic [AW-1:0] addr;
        logic [22:0] odd, even;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_ovf = 0; m_n = 0; m_poly = 0; m_addr = 0;
        held.delete();
        e_wen = 0; e_pd = 0; e_ready = 0; e_done = 0; e_ovf = 0; e_addr = '0; e_din = '0;
    endtask

    task automatic model(input logic st, input logic v, input logic [1:0] c,
                         input logic [22:0] a, input logic [22:0] b);
        logic [22:0] cs[$];
        e_wen = 0;
        e_pd  = 0;
        if (!m_run) begin
            if (st) begin
                m_run = 1; m_done = 0; m_ovf = 0; m_n = 0; m_poly = 0; m_addr = 0;
                held.delete();
            end
        end else if (v) begin
            if (c == 2'd3) m_ovf = 1;
            else begin
                if (c >= 2'd1) cs.push_back(a);
                if (c == 2'd2) cs.push_back(b);
            end
            if (cs.size() > 256 - m_n) m_ovf = 1;
            while (cs.size() > 256 - m_n) void'(cs.pop_back());
            foreach (cs[i]) begin
                held.push_back(cs[i]);
                m_n++;
                if (held.size() == 2) begin
                    e_wen  = 1;
                    e_addr = AW'(m_addr);
                    e_din  = DLEN'({held[1], held[0]});
                    m_addr++;
                    held.delete();
                end
                if (m_n == 256) begin
                    e_pd = 1;
                    m_n  = 0;
                    m_poly++;
                    if (m_poly == NPOLY) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end
        end
        e_ready = m_run;
        e_done  = m_done;
        e_ovf   = m_ovf;
    endtask

    task automatic check_model();
        chk("wen", 64'(bus.mem_wen), 64'(e_wen));
        chk("poly_done", 64'(bus.poly_done), 64'(e_pd));
        chk("ready", 64'(bus.coef_ready), 64'(e_ready));
        chk("done", 64'(bus.done), 64'(e_done));
        chk("overflow_err", 64'(bus.overflow_err), 64'(e_ovf));
        if (e_wen) begin
            chk("waddr", 64'(bus.mem_waddr), 64'(e_addr));
            chk("din", 64'(bus.mem_din), 64'(e_din));
        end
    endtask

    task automatic step(input logic st, input logic v, input logic [1:0] c,
                        input logic [22:0] a, input logic [22:0] b);
        @(negedge clk);
        bus.start      = st;
        bus.coef_valid = v;
        bus.coef_cnt   = c;
        bus.coef0      = a;
        bus.coef1      = b;
        model(st, v, c, a, b);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, 64'(bus.coef_ready), 64'd0);
        chk({nm, "_wen"}, 64'(bus.mem_wen), 64'd0);
        chk({nm, "_waddr"}, 64'(bus.mem_waddr), 64'd0);
        chk({nm, "_din"}, 64'(bus.mem_din), 64'd0);
        chk({nm, "_pdone"}, 64'(bus.poly_done), 64'd0);
        chk({nm, "_done"}, 64'(bus.done), 64'd0);
        chk({nm, "_ovf"}, 64'(bus.overflow_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] c;
        tbl[0]  = '{1, 0, 2'd0, 23'd0,  23'd0,  0, 11'd0, 23'd0,  23'd0};
        tbl[1]  = '{0, 1, 2'd1, 23'd5,  23'd0,  0, 11'd0, 23'd0,  23'd0};
        tbl[2]  = '{0, 1, 2'd1, 23'd7,  23'd0,  1, 11'd0, 23'd7,  23'd5};
        tbl[3]  = '{0, 1, 2'd1, 23'd9,  23'd0,  0, 11'd0, 23'd0,  23'd0};
        tbl[4]  = '{0, 1, 2'd1, 23'd11, 23'd0,  1, 11'd1, 23'd11, 23'd9};
        tbl[5]  = '{0, 1, 2'd1, 23'd20, 23'd0,  0, 11'd0, 23'd0,  23'd0};
        tbl[6]  = '{0, 1, 2'd2, 23'd21, 23'd22, 1, 11'd2, 23'd21, 23'd20};
        tbl[7]  = '{0, 1, 2'd1, 23'd23, 23'd0,  1, 11'd3, 23'd23, 23'd22};
        tbl[8]  = '{0, 1, 2'd0, 23'd30, 23'd31, 0, 11'd0, 23'd0,  23'd0};
        tbl[9]  = '{0, 0, 2'd2, 23'd32, 23'd33, 0, 11'd0, 23'd0,  23'd0};
        tbl[10] = '{0, 1, 2'd3, 23'd34, 23'd35, 0, 11'd0, 23'd0,  23'd0};

        reset = 1'b0;
        bus.start = 0; bus.coef_valid = 0; bus.coef_cnt = 0; bus.coef0 = 0; bus.coef1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fill poly 0 to 255 with single beats, then overflow with a pair
        step(1, 0, 2'd0, 23'd0, 23'd0);
        for (int i = 0; i < 255; i++) step(0, 1, 2'd1, 23'(i + 1000), 23'd0);
        step(0, 1, 2'd2, 23'd4444, 23'd5555);
        chk("t4_pdone", 64'(bus.poly_done), 64'd1);
        chk("t4_ovf", 64'(bus.overflow_err), 64'd1);
        chk("t4_addr", 64'(bus.mem_waddr), 64'd127);
        chk("t4_din", 64'(bus.mem_din), {18'd0, 23'd4444, 23'd1254});

        // Last poly with pairs 2i/2i+1 lands at addr 128+i
        for (int i = 0; i < 128; i++) begin
            step(0, 1, 2'd2, 23'(2 * i), 23'(2 * i + 1));
            if (i == 0) chk("t1_first_addr", 64'(bus.mem_waddr), 64'd128);
        end
        chk("t1_pdone", 64'(bus.poly_done), 64'd1);
        chk("t5_last_addr", 64'(bus.mem_waddr), 64'd255);
        chk("t5_last_din", 64'(bus.mem_din), {18'd0, 23'd255, 23'd254});
        chk("t5_done", 64'(bus.done), 64'd1);
        chk("t5_ready", 64'(bus.coef_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'd2, 23'd1, 23'd2);
            chk("t5_no_write", 64'(bus.mem_wen), 64'd0);
        end

        // Restart from DONE through the vector table
        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].b);
            chk("tbl_wen", 64'(bus.mem_wen), 64'(tbl[i].wen));
            if (tbl[i].wen) begin
                chk("tbl_addr", 64'(bus.mem_waddr), 64'(tbl[i].addr));
                chk("tbl_din", 64'(bus.mem_din), DLEN'({tbl[i].odd, tbl[i].even}));
            end
            if (i == 0) chk("tbl_ovf_cleared", 64'(bus.overflow_err), 64'd0);
        end
        chk("tbl_ovf_cnt3", 64'(bus.overflow_err), 64'd1);

        // Random beats until the vector completes
        n = 0;
        while (!m_done && n < 3000) begin
            c = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), c,
                 23'($urandom), 23'($urandom));
            n++;
        end
        chk("rand_done", 64'(bus.done), 64'd1);

        // Async reset mid-polynomial with a held coefficient
        step(1, 0, 2'd0, 23'd0, 23'd0);
        step(0, 1, 2'd1, 23'd10, 23'd0);
        step(0, 1, 2'd3, 23'd0, 23'd0);
        step(0, 1, 2'd1, 23'd11, 23'd0);
        step(0, 1, 2'd1, 23'd12, 23'd0);
        chk("t6_pre_ready", 64'(bus.coef_ready), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("t6_async");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 2'd2, 23'd1, 23'd2);
        step(0, 0, 2'd0, 23'd0, 23'd0);
        step(1, 0, 2'd0, 23'd0, 23'd0);
        step(0, 1, 2'd2, 23'd100, 23'd101);
        chk("t6_refill_addr", 64'(bus.mem_waddr), 64'd0);
        chk("t6_refill_din", 64'(bus.mem_din), {18'd0, 23'd101, 23'd100});
        step(0, 1, 2'd1, 23'd102, 23'd0);
        step(0, 1, 2'd1, 23'd103, 23'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
